// File: rtl/stage4_decode_queue.sv
// ---------------------------------------------------------------------------
// stage4_decode_queue
//   Instruction queue between decode and execute. Decoded bundles written by
//   decode are buffered and the oldest is presented to execute,
//   first-word-fall-through. Fullness is reported to the hazard unit, and the
//   queue obeys its stall_queue / flush_queue controls.
//
// Ports
//   CLK           in   pipeline clock
//   nRST          in   asynchronous active-low reset
//   queue_wen     in   decode pushes wdata/wpc this cycle
//   wdata         in   decoded bundle [DATA_W]
//   wpc           in   PC of pushed instruction [32]
//   stall_queue   in   hold head, no dequeue
//   flush_queue   in   discard all entries (overrides push/pop)
//   ex_ready      in   execute accepts head this cycle
//   is_queue_full out  occupancy == DEPTH
//   valid_out     out  head entry valid
//   rdata         out  head bundle [DATA_W], 0 when empty
//   rpc           out  head PC [32], 0 when empty
//   count         out  current occupancy [$clog2(DEPTH)+1]
// ---------------------------------------------------------------------------
module stage4_decode_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 96
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     queue_wen,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [31:0]              wpc,
    input  logic                     stall_queue,
    input  logic                     flush_queue,
    input  logic                     ex_ready,
    output logic                     is_queue_full,
    output logic                     valid_out,
    output logic [DATA_W-1:0]        rdata,
    output logic [31:0]              rpc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit above the index bits.
    logic [IDX_W:0]      wr_ptr;
    logic [IDX_W:0]      rd_ptr;

    // Storage is intentionally not reset; outputs are gated when empty.
    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic [31:0]         mem_pc   [DEPTH];

    logic                empty;
    logic                push;
    logic                pop;

    always_comb begin
        empty         = (wr_ptr == rd_ptr);
        is_queue_full = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        valid_out     = !empty;
        count         = wr_ptr - rd_ptr;
        // Push is refused when full even if a pop happens the same cycle,
        // keeping fullness a function of registered state only.
        push          = queue_wen && !is_queue_full && !flush_queue;
        pop           = valid_out && ex_ready && !stall_queue && !flush_queue;
        rdata         = '0;
        rpc           = '0;
        if (!empty) begin
            rdata = mem_data[rd_ptr[IDX_W-1:0]];
            rpc   = mem_pc[rd_ptr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush_queue) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[wr_ptr[IDX_W-1:0]] <= wdata;
            mem_pc[wr_ptr[IDX_W-1:0]]   <= wpc;
        end
    end

endmodule

// File: tb/tb_stage4_decode_queue.sv
// ---------------------------------------------------------------------------
// tb_stage4_decode_queue
//   Table-driven bench for the decode/execute instruction queue. Each table
//   record carries the inputs for one cycle plus the expected occupancy,
//   full flag, valid flag and head PC. A PC scoreboard (queue) tracks the
//   pushed bundles independently and checks head data ordering. The async
//   reset case is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_stage4_decode_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 96;

    logic              CLK;
    logic              nRST;
    logic              queue_wen;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       wpc;
    logic              stall_queue;
    logic              flush_queue;
    logic              ex_ready;
    logic              is_queue_full;
    logic              valid_out;
    logic [DATA_W-1:0] rdata;
    logic [31:0]       rpc;
    logic [2:0]        count;

    stage4_decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .queue_wen     (queue_wen),
        .wdata         (wdata),
        .wpc           (wpc),
        .stall_queue   (stall_queue),
        .flush_queue   (flush_queue),
        .ex_ready      (ex_ready),
        .is_queue_full (is_queue_full),
        .valid_out     (valid_out),
        .rdata         (rdata),
        .rpc           (rpc),
        .count         (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wen;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        rdy;
        int unsigned ecount;
        logic        efull;
        logic        evalid;
        logic [31:0] erpc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [DATA_W-1:0] mk_data(input logic [31:0] pc);
        return {pc ^ 32'hDEAD_BEEF, ~pc, pc + 32'h1234_5678};
    endfunction

    function automatic vec_t mk(input logic wen, input logic [31:0] pc,
                                input logic stall, input logic flush,
                                input logic rdy, input int unsigned ecount,
                                input logic efull, input logic evalid,
                                input logic [31:0] erpc);
        vec_t v;
        v.wen = wen; v.pc = pc; v.stall = stall; v.flush = flush; v.rdy = rdy;
        v.ecount = ecount; v.efull = efull; v.evalid = evalid; v.erpc = erpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int unsigned ecount,
                                 input logic efull, input logic evalid,
                                 input logic [31:0] erpc);
        logic [31:0]       sb_pc;
        logic [DATA_W-1:0] sb_data;
        check({tag, " count"}, 128'(count), 128'(ecount));
        check({tag, " full"},  128'(is_queue_full), 128'(efull));
        check({tag, " valid"}, 128'(valid_out), 128'(evalid));
        check({tag, " rpc"},   128'(rpc), 128'(erpc));
        sb_pc   = (sb.size() != 0) ? sb[0] : 32'h0;
        sb_data = (sb.size() != 0) ? mk_data(sb[0]) : '0;
        check({tag, " sb_rpc"},   128'(rpc), 128'(sb_pc));
        check({tag, " sb_rdata"}, 128'(rdata), 128'(sb_data));
        check({tag, " sb_count"}, 128'(count), 128'(sb.size()));
    endtask

    // Called just after a falling edge: drives inputs, updates the
    // scoreboard at the rising edge, checks shortly after, returns at the
    // next falling edge.
    task automatic apply(input vec_t v, input string tag);
        logic push, pop;
        queue_wen   = v.wen;
        wpc         = v.pc;
        wdata       = mk_data(v.pc);
        stall_queue = v.stall;
        flush_queue = v.flush;
        ex_ready    = v.rdy;
        push = v.wen && (sb.size() < DEPTH) && !v.flush;
        pop  = (sb.size() != 0) && v.rdy && !v.stall && !v.flush;
        @(posedge CLK);
        if (v.flush) sb.delete();
        else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(v.pc);
        end
        #2;
        check_outputs(tag, v.ecount, v.efull, v.evalid, v.erpc);
        @(negedge CLK);
        queue_wen = 1'b0; stall_queue = 1'b0; flush_queue = 1'b0; ex_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0; queue_wen = 1'b0; wpc = '0; wdata = '0;
        stall_queue = 1'b0; flush_queue = 1'b0; ex_ready = 1'b0;

        // Test 1: fill to full with execute not ready
        vecs.push_back(mk(1, 32'h200, 0, 0, 0, 1, 0, 1, 32'h200));
        vecs.push_back(mk(1, 32'h204, 0, 0, 0, 2, 0, 1, 32'h200));
        vecs.push_back(mk(1, 32'h208, 0, 0, 0, 3, 0, 1, 32'h200));
        vecs.push_back(mk(1, 32'h20C, 0, 0, 0, 4, 1, 1, 32'h200));
        // Test 2: push while full is dropped, pop still happens
        vecs.push_back(mk(1, 32'h210, 0, 0, 1, 3, 0, 1, 32'h204));
        // Test 3: drain to 2, then push+pop for 10 cycles across wraps
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 2, 0, 1, 32'h208));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(1, 32'h400 + 32'(4 * i), 0, 0, 1, 2, 0, 1,
                              (i == 0) ? 32'h20C : 32'h400 + 32'(4 * (i - 1))));
        // Test 4: occupancy 3, stall with ex_ready still accepts a push
        vecs.push_back(mk(1, 32'h430, 0, 0, 0, 3, 0, 1, 32'h420));
        vecs.push_back(mk(1, 32'h434, 1, 0, 1, 4, 1, 1, 32'h420));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 3, 0, 1, 32'h424));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 2, 0, 1, 32'h430));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 1, 0, 1, 32'h434));
        vecs.push_back(mk(1, 32'h440, 0, 0, 0, 2, 0, 1, 32'h434));
        vecs.push_back(mk(1, 32'h444, 0, 0, 0, 3, 0, 1, 32'h434));
        // Test 5: flush overrides concurrent push, pop and stall
        vecs.push_back(mk(1, 32'h448, 1, 1, 1, 0, 0, 0, 32'h0));
        // Empty: ex_ready ignored, no underflow
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 0, 0, 0, 32'h0));
        // Push into empty with ex_ready: no bypass, entry stays
        vecs.push_back(mk(1, 32'h500, 0, 0, 1, 1, 0, 1, 32'h500));
        vecs.push_back(mk(0, 32'h0,   0, 0, 1, 0, 0, 0, 32'h0));

        repeat (2) @(negedge CLK);
        check_outputs("reset", 0, 0, 0, 32'h0);
        nRST = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Test 6: async reset mid-cycle with pushes in flight
        apply(mk(1, 32'h600, 0, 0, 0, 1, 0, 1, 32'h600), "rst_pre0");
        apply(mk(1, 32'h604, 0, 0, 0, 2, 0, 1, 32'h600), "rst_pre1");
        queue_wen = 1'b1; wpc = 32'h608; wdata = mk_data(32'h608);
        #2 nRST = 1'b0;
        sb.delete();
        #1 check_outputs("rst_async", 0, 0, 0, 32'h0);
        @(posedge CLK);
        #2 check_outputs("rst_held", 0, 0, 0, 32'h0);
        @(negedge CLK);
        queue_wen = 1'b0;
        #1 nRST = 1'b1;
        apply(mk(1, 32'h300, 0, 0, 0, 1, 0, 1, 32'h300), "rst_post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
